// File: rtl/file_ctrl_if.sv
// Command/response and register-file port bundle for file_ctrl.
// slave  : the sequencer (takes commands, drives the file port).
// master : the environment (core issuing commands, register file returning file_out).
interface file_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    // Command channel: a command transfers on a rising edge where
    // cmd_valid and cmd_ready are both high; cmd_ready is high only while
    // the sequencer is idle, and nothing offered while it is busy is taken.
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_addr2;
    logic [DW-1:0] cmd_data;

    // Response: single-cycle pulse, rsp_err qualifies it.
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;

    // Register file access port.
    logic          file_en;
    logic [3:0]    operation;
    logic [AW-1:0] addr;
    logic [DW-1:0] ac;
    logic [DW-1:0] file_out;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_data, file_out,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output file_en, operation, addr, ac
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_addr2, cmd_data, file_out,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  file_en, operation, addr, ac
    );
endinterface

// File: rtl/file_ctrl.sv
// file_ctrl: initiator-side sequencer for the CPU register file port.
// Runs LOAD / STORE / COPY / XCHG one at a time and returns a one-cycle
// response. Optional build macro FILE_CTRL_VERIFY_EN adds a read-back of
// every write (WR -> RD2 -> RW2 -> DONE) that flags a mismatch in rsp_err.
module file_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic       clk,
    input  logic       rst,
    file_ctrl_if.slave bus,
    output logic [2:0] state_dbg
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_XCHG  = 2'b11;

    localparam logic [3:0] FOP_READ  = 4'b0000;
    localparam logic [3:0] FOP_WRITE = 4'b0001;

`ifdef FILE_CTRL_VERIFY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RW   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4,
        S_RD2  = 3'd5,
        S_RW2  = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_RW   = 3'd2,
        S_WR   = 3'd3,
        S_DONE = 3'd4
    } state_t;
`endif

    state_t state_q;
    state_t state_d;

    // Latched command and temp register.
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr2_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] temp_q;

    // Registered response.
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;
    logic          rsp_err_q;

    logic          accept;
    logic          cmd_ok;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_val;

    function automatic logic addr_in_range(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    assign accept = bus.cmd_valid && bus.cmd_ready;

    // COPY uses both addresses; every other op uses only cmd_addr.
    assign cmd_ok = addr_in_range(bus.cmd_addr) &&
                    ((bus.cmd_op != OP_COPY) || addr_in_range(bus.cmd_addr2));

    // COPY writes the read value to the second address; the rest write cmd_data to cmd_addr.
    assign wr_addr = (op_q == OP_COPY) ? addr2_q : addr_q;
    assign wr_val  = (op_q == OP_COPY) ? temp_q  : data_q;

    assign state_dbg = state_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!cmd_ok) begin
                        state_d = S_DONE;
                    end else if (bus.cmd_op == OP_STORE) begin
                        state_d = S_WR;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD:   state_d = S_RW;
            S_RW:   state_d = (op_q == OP_LOAD) ? S_DONE : S_WR;
`ifdef FILE_CTRL_VERIFY_EN
            S_WR:   state_d = S_RD2;
            S_RD2:  state_d = S_RW2;
            S_RW2:  state_d = S_DONE;
`else
            S_WR:   state_d = S_DONE;
`endif
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // File-port and handshake outputs decoded from state and latched command.
    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.file_en   = 1'b0;
        bus.operation = FOP_READ;
        bus.addr      = '0;
        bus.ac        = '0;
        case (state_q)
            S_IDLE: bus.cmd_ready = 1'b1;
            S_RD: begin
                bus.file_en   = 1'b1;
                bus.operation = FOP_READ;
                bus.addr      = addr_q;
            end
            S_WR: begin
                bus.file_en   = 1'b1;
                bus.operation = FOP_WRITE;
                bus.addr      = wr_addr;
                bus.ac        = wr_val;
            end
`ifdef FILE_CTRL_VERIFY_EN
            S_RD2: begin
                bus.file_en   = 1'b1;
                bus.operation = FOP_READ;
                bus.addr      = wr_addr;
            end
`endif
            default: ;
        endcase
    end

    // Command latch and temp capture at the edge closing RW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            addr2_q <= '0;
            data_q  <= '0;
            temp_q  <= '0;
        end else begin
            if (accept) begin
                op_q    <= bus.cmd_op;
                addr_q  <= bus.cmd_addr;
                addr2_q <= bus.cmd_addr2;
                data_q  <= bus.cmd_data;
            end
            if (state_q == S_RW) begin
                temp_q <= bus.file_out;
            end
        end
    end

    // Response registers: loaded on the edge entering DONE, pulse lasts one cycle,
    // rsp_data is held until the next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_d == S_DONE);
            rsp_err_q   <= 1'b0;
            if (state_d == S_DONE) begin
                case (state_q)
                    S_IDLE: begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end
                    S_RW:   rsp_data_q <= bus.file_out;
                    S_WR:   rsp_data_q <= (op_q == OP_STORE) ? data_q : temp_q;
`ifdef FILE_CTRL_VERIFY_EN
                    S_RW2: begin
                        rsp_data_q <= (op_q == OP_STORE) ? data_q : temp_q;
                        rsp_err_q  <= (bus.file_out != wr_val);
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_file_ctrl.sv
// Testbench for file_ctrl: directed commands against a behavioural
// 16-entry register file (files[i]=i after its own reset).
module tb_file_ctrl;

`ifdef FILE_CTRL_VERIFY_EN
    localparam int VER = 1;
`else
    localparam int VER = 0;
`endif

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_XCHG  = 2'b11;

    logic       clk;
    logic       rst;
    logic       file_rst;
    logic [2:0] state_dbg;

    file_ctrl_if #(.AW(8), .DW(8)) bus ();

    file_ctrl #(.DEPTH(16), .AW(8), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- register file model ----------------
    logic [7:0] mem [16];

    always @(posedge clk or posedge file_rst) begin
        if (file_rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'(i);
            bus.file_out <= 8'h00;
        end else if (bus.file_en && bus.addr < 8'd16) begin
            if (bus.operation == 4'b0001) mem[bus.addr[3:0]] <= bus.ac;
            else if (bus.operation == 4'b0000) bus.file_out <= mem[bus.addr[3:0]];
        end
    end

    // ---------------- file port monitor ----------------
    int         en_cnt, rd_cnt, wr_cnt, bad_cnt, rspv_cnt;
    logic [7:0] last_rd_addr, last_wr_addr, last_wr_ac;

    always @(negedge clk) begin
        if (bus.file_en) begin
            en_cnt++;
            if (bus.operation == 4'b0000) begin
                rd_cnt++;
                last_rd_addr = bus.addr;
            end else if (bus.operation == 4'b0001) begin
                wr_cnt++;
                last_wr_addr = bus.addr;
                last_wr_ac   = bus.ac;
            end else begin
                bad_cnt++;
            end
        end
        if (bus.rsp_valid) rspv_cnt++;
    end

    task automatic clear_mon();
        en_cnt = 0; rd_cnt = 0; wr_cnt = 0; bad_cnt = 0; rspv_cnt = 0;
        last_rd_addr = 8'hxx; last_wr_addr = 8'hxx; last_wr_ac = 8'hxx;
    endtask

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic offer(input logic [1:0] op, input logic [7:0] a, input logic [7:0] a2,
                         input logic [7:0] d);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = a;
        bus.cmd_addr2 = a2;
        bus.cmd_data  = d;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom_range(0, 3));
        bus.cmd_addr  = 8'($urandom_range(0, 255));
        bus.cmd_addr2 = 8'($urandom_range(0, 255));
        bus.cmd_data  = 8'($urandom_range(0, 255));
    endtask

    // Issue one command and check response data/err/latency and the cycle after.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] a,
                           input logic [7:0] a2, input logic [7:0] d,
                           input logic [7:0] exp_data, input logic exp_err, input int exp_lat);
        int lat;
        logic [7:0] e;
        exp_q.push_back(exp_data);
        clear_mon();
        offer(op, a, a2, d);
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid) break;
        end
        e = exp_q.pop_front();
        if (!bus.rsp_valid) begin
            check({tag, "_timeout"}, 32'(0), 32'(1));
        end else begin
            check({tag, "_lat"},  32'(lat),          32'(exp_lat));
            check({tag, "_data"}, 32'(bus.rsp_data), 32'(e));
            check({tag, "_err"},  32'(bus.rsp_err),  32'(exp_err));
            @(negedge clk);
            check({tag, "_vdrop"}, 32'(bus.rsp_valid), 32'(0));
            check({tag, "_hold"},  32'(bus.rsp_data),  32'(e));
            check({tag, "_ready"}, 32'(bus.cmd_ready), 32'(1));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 8'h00;
        bus.cmd_addr2 = 8'h00;
        bus.cmd_data  = 8'h00;
        clear_mon();
        rst      = 1'b1;
        file_rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // reset state
        check("rst_ready", 32'(bus.cmd_ready), 32'(1));
        check("rst_rspv",  32'(bus.rsp_valid), 32'(0));
        check("rst_rspd",  32'(bus.rsp_data),  32'(0));
        check("rst_rspe",  32'(bus.rsp_err),   32'(0));
        check("rst_en",    32'(bus.file_en),   32'(0));
        check("rst_fop",   32'(bus.operation), 32'(0));
        check("rst_addr",  32'(bus.addr),      32'(0));
        check("rst_ac",    32'(bus.ac),        32'(0));
        check("rst_state", 32'(state_dbg),     32'(0));
        rst      = 1'b0;
        file_rst = 1'b0;
        repeat (2) @(negedge clk);

        // LOAD 5: one read at addr 5, no other activity
        run_cmd("load5", OP_LOAD, 8'd5, 8'd0, 8'd0, 8'h05, 1'b0, 3);
        check("load5_rd",   32'(rd_cnt),       32'(1));
        check("load5_en",   32'(en_cnt),       32'(1));
        check("load5_addr", 32'(last_rd_addr), 32'(5));

        // STORE 3 <- A5, then LOAD 3
        run_cmd("store3", OP_STORE, 8'd3, 8'd0, 8'hA5, 8'hA5, 1'b0, 2 + 2 * VER);
        check("store3_wr",   32'(wr_cnt),       32'(1));
        check("store3_rd",   32'(rd_cnt),       32'(VER));
        check("store3_waddr", 32'(last_wr_addr), 32'(3));
        check("store3_ac",   32'(last_wr_ac),   32'(8'hA5));
        run_cmd("load3", OP_LOAD, 8'd3, 8'd0, 8'd0, 8'hA5, 1'b0, 3);

        // COPY 7 -> 12, then LOAD 12 and LOAD 7
        run_cmd("copy", OP_COPY, 8'd7, 8'd12, 8'hEE, 8'h07, 1'b0, 4 + 2 * VER);
        check("copy_waddr", 32'(last_wr_addr), 32'(12));
        check("copy_ac",    32'(last_wr_ac),   32'(8'h07));
        check("copy_rd",    32'(rd_cnt),       32'(1 + VER));
        run_cmd("load12", OP_LOAD, 8'd12, 8'd0, 8'd0, 8'h07, 1'b0, 3);
        run_cmd("load7",  OP_LOAD, 8'd7,  8'd0, 8'd0, 8'h07, 1'b0, 3);

        // XCHG 9 <-> 3C, then LOAD 9
        run_cmd("xchg", OP_XCHG, 8'd9, 8'd0, 8'h3C, 8'h09, 1'b0, 4 + 2 * VER);
        check("xchg_waddr", 32'(last_wr_addr), 32'(9));
        check("xchg_ac",    32'(last_wr_ac),   32'(8'h3C));
        run_cmd("load9", OP_LOAD, 8'd9, 8'd0, 8'd0, 8'h3C, 1'b0, 3);

        // boundary addresses
        run_cmd("load15", OP_LOAD, 8'd15, 8'd0, 8'd0, 8'h0F, 1'b0, 3);
        run_cmd("load16", OP_LOAD, 8'h10, 8'd0, 8'd0, 8'h00, 1'b1, 1);
        check("load16_en", 32'(en_cnt), 32'(0));
        run_cmd("copy_bad2", OP_COPY, 8'd2, 8'h20, 8'd0, 8'h00, 1'b1, 1);
        check("copy_bad2_en", 32'(en_cnt), 32'(0));
        run_cmd("copy_bad1", OP_COPY, 8'hFF, 8'd2, 8'd0, 8'h00, 1'b1, 1);
        check("copy_bad1_en", 32'(en_cnt), 32'(0));
        run_cmd("store16", OP_STORE, 8'h10, 8'd0, 8'h55, 8'h00, 1'b1, 1);
        check("store16_en", 32'(en_cnt), 32'(0));
        // COPY's addr2 is ignored for non-COPY ops
        run_cmd("load_a2", OP_LOAD, 8'd2, 8'hFF, 8'd0, 8'h02, 1'b0, 3);

        check("no_bad_fop", 32'(bad_cnt), 32'(0));

        // reset during RW of an XCHG on entry 4
        clear_mon();
        offer(OP_XCHG, 8'd4, 8'd0, 8'h77);
        @(negedge clk);
        check("abort_rd_state", 32'(state_dbg), 32'(1));
        @(negedge clk);
        check("abort_rw_state", 32'(state_dbg), 32'(2));
        rst = 1'b1;
        #1;
        check("abort_rw_en",    32'(bus.file_en), 32'(0));
        check("abort_rw_idle",  32'(state_dbg),   32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_rw_norsp", 32'(rspv_cnt), 32'(0));
        check("abort_rw_nowr",  32'(wr_cnt),   32'(0));
        check("abort_rw_ready", 32'(bus.cmd_ready), 32'(1));
        run_cmd("abort_rw_load4", OP_LOAD, 8'd4, 8'd0, 8'd0, 8'h04, 1'b0, 3);

        // reset during the WR cycle of a STORE on entry 6
        clear_mon();
        offer(OP_STORE, 8'd6, 8'd0, 8'hEE);
        @(negedge clk);
        check("abort_wr_en1", 32'(bus.file_en), 32'(1));
        rst = 1'b1;
        #1;
        check("abort_wr_en0", 32'(bus.file_en), 32'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_wr_norsp", 32'(rspv_cnt), 32'(0));
        run_cmd("abort_wr_load6", OP_LOAD, 8'd6, 8'd0, 8'd0, 8'h06, 1'b0, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/file_ctrl.md
Name: file_ctrl

Overview:
- Initiator-side sequencer for the CPU register file access port.
- Accepts one command at a time from the core over a valid/ready handshake and drives the file port: file_en, 4-bit operation, addr, ac.
- Supported commands: LOAD, STORE, COPY and XCHG. Results come back as a single-cycle response pulse.
- Sits between the decode/execute logic and the register file; the only block that drives the file port.

Parameters:
- DEPTH, 16, number of valid file entries; addresses >= DEPTH are rejected.
- AW, 8, address width of cmd and file port.
- DW, 8, data width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  00 LOAD, 01 STORE, 10 COPY, 11 XCHG
- cmd_addr  in  AW  target (LOAD/STORE/XCHG) or source (COPY)
- cmd_addr2  in  AW  COPY destination; ignored otherwise
- cmd_data  in  DW  write data for STORE/XCHG
- rsp_valid  out  1  one-cycle completion pulse
- rsp_data  out  DW  result data
- rsp_err  out  1  qualifies rsp_valid; address out of range
- file_en  out  1  file port enable
- operation  out  4  0000 read, 0001 write; other codes never driven
- addr  out  AW  file address
- ac  out  DW  file write data
- file_out  in  DW  file read data, registered by the file one edge after a read is issued

Behaviour:
- Reset: state IDLE, all latched command registers 0, rsp_valid=0, rsp_data=0, rsp_err=0.
- Reset mid-operation aborts the command with no response. file_en drops immediately.
- File-port outputs are decoded from the current state and the latched command.
  - When not issuing: file_en=0, operation=0000, addr=0, ac=0.
- Accept: cmd_valid & cmd_ready at a rising edge latches op, addr, addr2 and data. cmd_ready=0 in every state except IDLE.
- States: IDLE, RD (issue read), RW (wait for read data), WR (issue write), DONE.
- In RD: file_en=1, operation=0000, addr=latched read address.
  - The read address is cmd_addr for all ops.
- In RW: file port idle. At the closing edge, file_out is captured into the temp register.
- In WR: file_en=1, operation=0001, addr=write address, ac=write value.
  - COPY: write address is cmd_addr2, write value is temp.
  - Other ops: write address is cmd_addr, write value is cmd_data.
- Transitions:
  - LOAD: IDLE→RD→RW→DONE. rsp_data=temp.
  - STORE: IDLE→WR→DONE. rsp_data=cmd_data.
  - COPY: IDLE→RD→RW→WR→DONE. rsp_data=copied value.
  - XCHG: IDLE→RD→RW→WR→DONE. rsp_data=old contents (temp).
- rsp_valid, rsp_data and rsp_err are registered; they are valid for exactly the DONE cycle. DONE→IDLE unconditionally.
- rsp_data holds its value after DONE until the next response. rsp_valid and rsp_err return to 0.
- Latency from the accept edge to the rsp_valid cycle: LOAD 3, STORE 2, COPY 4, XCHG 4.
  - Next accept is possible in the cycle after DONE.
- Range check at accept: any used address >= DEPTH (COPY checks both addresses) skips all file accesses.
  - Goes IDLE→DONE with rsp_err=1 and rsp_data=0.
- cmd_valid while busy is ignored. Inputs may change freely after accept.

Optional Feature:
- Macro FILE_CTRL_VERIFY_EN.
- When defined, STORE, COPY and XCHG add a read-back after WR: WR→RD2→RW2→DONE.
  - RD2 reads the write address.
  - At the edge closing RW2, file_out is compared with the written value. A mismatch sets rsp_err=1.
  - rsp_data is unchanged by the read-back.
  - Latencies become STORE 4, COPY 6, XCHG 6.
- When undefined, RD2/RW2 do not exist and the latencies are those listed above.

Test Plan:
- Register file holds files[i]=i after its reset. LOAD addr=5 → rsp_valid 3 cycles after accept, rsp_data=0x05, rsp_err=0. The only file activity is one read cycle at addr 5.
- STORE addr=3 data=0xA5, then LOAD addr=3 → write cycle with operation=0001, addr=3, ac=0xA5; LOAD returns 0xA5.
- COPY addr=7 addr2=12, then LOAD 12 → COPY rsp_data=0x07; LOAD returns 0x07; entry 7 unchanged.
- XCHG addr=9 data=0x3C → rsp_data=0x09 at latency 4; a following LOAD 9 returns 0x3C.
- LOAD addr=0x10, and COPY addr=2 addr2=0x20 → rsp_err=1, rsp_data=0, file_en never asserted, latency 1.
- Assert rst during the RW cycle of an XCHG → file_en=0 immediately, no rsp_valid, and entry unchanged. After release, cmd_ready=1 and LOAD returns the original value.
